// File: rtl/ssi_poll_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ssi_poll_scheduler
// Brief    : Time-multiplexes one shared SSI bus (ssi_clk/ssi_data) across
//            NUM_ENC absolute encoders with individual active-low selects.
//            A poll timer or an external trigger starts a sweep that reads
//            every encoder enabled in the latched mask, lowest index first.
//            Optional feature macro: SSI_PARITY_EN appends an even-parity bit
//            to each frame and suppresses the update on a parity failure.
// Revision : 1.0  initial release
// ============================================================================
module ssi_poll_scheduler #(
    parameter int NUM_ENC     = 4,
    parameter int RES         = 10,
    parameter int STAT_BITS   = 2,
    parameter int CLK_DIV     = 50,
    parameter int CS_SETUP    = 50,
    parameter int CS_GAP      = 100,
    parameter int POLL_CYCLES = 100000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         trigger,
    input  logic [NUM_ENC-1:0]           enc_mask,
    input  logic                         ssi_data,
    output logic                         ssi_clk,
    output logic [NUM_ENC-1:0]           ncs,
    output logic [NUM_ENC*RES-1:0]       pos_out,
    output logic [NUM_ENC*STAT_BITS-1:0] stat_out,
    output logic [NUM_ENC-1:0]           pos_valid,
    output logic                         busy,
    output logic [NUM_ENC-1:0]           parity_err
);

`ifdef SSI_PARITY_EN
    localparam int c_PAR = 1;
`else
    localparam int c_PAR = 0;
`endif
    localparam int c_FRAME_BITS = RES + STAT_BITS + c_PAR;
    localparam int c_IW   = (NUM_ENC > 1) ? $clog2(NUM_ENC) : 1;
    localparam int c_TW   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int c_CMAX = (CS_SETUP > 2*CLK_DIV) ?
                            ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                            ((2*CLK_DIV > CS_GAP) ? 2*CLK_DIV : CS_GAP);
    localparam int c_CW   = $clog2(c_CMAX + 1);
    localparam int c_BW   = $clog2(c_FRAME_BITS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;

    logic [2:0]                   r_state, w_next;
    logic [c_TW-1:0]              r_timer;
    logic                         r_pending;
    logic [NUM_ENC-1:0]           r_mask;
    logic [c_IW-1:0]              r_idx;
    logic [c_CW-1:0]              r_cnt;
    logic [c_BW-1:0]              r_bit;
    logic [c_FRAME_BITS-1:0]      r_shift;
    logic [NUM_ENC*RES-1:0]       r_pos;
    logic [NUM_ENC*STAT_BITS-1:0] r_stat;

    logic            w_tick, w_req, w_start;
    logic            w_sel_end, w_bit_end, w_frame_end, w_gap_end, w_sample;
    logic            w_par_ok, w_next_found;
    logic [c_IW-1:0] w_first_idx, w_next_idx;

    assign w_tick      = enable && (r_timer == c_TW'(POLL_CYCLES - 1));
    assign w_req       = w_tick || trigger;
    assign w_start     = (r_state == S_IDLE) && (w_req || r_pending);
    assign w_sel_end   = (r_cnt == c_CW'(CS_SETUP - 1));
    assign w_bit_end   = (r_cnt == c_CW'(2*CLK_DIV - 1));
    assign w_frame_end = w_bit_end && (r_bit == c_BW'(c_FRAME_BITS - 1));
    assign w_gap_end   = (r_cnt == c_CW'(CS_GAP - 1));
    // The first clk cycle of each ssi_clk high phase captures the bit.
    assign w_sample    = (r_state == S_SHIFT) && (r_cnt == c_CW'(CLK_DIV));
`ifdef SSI_PARITY_EN
    // Even parity: the XOR over the whole frame, parity bit included, is 0.
    assign w_par_ok    = ~^r_shift;
`else
    assign w_par_ok    = 1'b1;
`endif

    // Lowest enabled encoder for a new sweep and next enabled one above r_idx.
    always_comb begin
        w_first_idx  = '0;
        w_next_idx   = '0;
        w_next_found = 1'b0;
        for (int i = NUM_ENC - 1; i >= 0; i--) begin
            if (enc_mask[i]) w_first_idx = c_IW'(i);
            if (r_mask[i] && (i > int'(r_idx))) begin
                w_next_found = 1'b1;
                w_next_idx   = c_IW'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; an all-zero mask leaves the scheduler idle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start && (|enc_mask)) w_next = S_SELECT;
            S_SELECT: if (w_sel_end)              w_next = S_SHIFT;
            S_SHIFT:  if (w_frame_end)            w_next = S_DONE;
            S_DONE:                               w_next = S_GAP;
            S_GAP:    if (w_gap_end)              w_next = w_next_found ? S_SELECT : S_IDLE;
            default:                              w_next = S_IDLE;
        endcase
    end

    // Poll timer, request coalescing, counters, shifter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer   <= '0;
            r_pending <= 1'b0;
            r_mask    <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_pos     <= '0;
            r_stat    <= '0;
        end else begin
            if (!enable)     r_timer <= '0;
            else if (w_tick) r_timer <= '0;
            else             r_timer <= r_timer + 1'b1;

            if ((r_state != S_IDLE) && w_req) r_pending <= 1'b1;
            else if (w_start)                 r_pending <= 1'b0;

            if (w_start) begin
                r_mask <= enc_mask;
                r_idx  <= w_first_idx;
            end else if ((r_state == S_GAP) && w_gap_end && w_next_found) begin
                r_idx  <= w_next_idx;
            end

            if ((w_next != r_state) || (r_state == S_IDLE) || (r_state == S_DONE))
                r_cnt <= '0;
            else if ((r_state == S_SHIFT) && w_bit_end)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            if (r_state == S_SELECT)                  r_bit <= '0;
            else if ((r_state == S_SHIFT) && w_bit_end) r_bit <= r_bit + 1'b1;

            if (w_sample) r_shift <= {r_shift[c_FRAME_BITS-2:0], ssi_data};

            // Result slices change on the edge entering DONE so they are
            // already valid while pos_valid is high.
            if ((r_state == S_SHIFT) && w_frame_end && w_par_ok) begin
                r_pos[r_idx*RES +: RES] <= r_shift[c_FRAME_BITS-1 -: RES];
                r_stat[r_idx*STAT_BITS +: STAT_BITS] <= r_shift[c_FRAME_BITS-1-RES -: STAT_BITS];
            end
        end
    end

    // Bus and strobe outputs decoded from the current state.
    always_comb begin
        ssi_clk   = !((r_state == S_SHIFT) && (r_cnt < c_CW'(CLK_DIV)));
        ncs       = '1;
        pos_valid = '0;
`ifdef SSI_PARITY_EN
        parity_err = '0;
`endif
        if ((r_state == S_SELECT) || (r_state == S_SHIFT)) ncs[r_idx] = 1'b0;
        if (r_state == S_DONE) begin
            if (w_par_ok) pos_valid[r_idx] = 1'b1;
`ifdef SSI_PARITY_EN
            else          parity_err[r_idx] = 1'b1;
`endif
        end
    end

`ifndef SSI_PARITY_EN
    assign parity_err = '0;
`endif
    assign busy     = (r_state != S_IDLE);
    assign pos_out  = r_pos;
    assign stat_out = r_stat;

endmodule
`default_nettype wire
